// File: rtl/psoc_audio_pkg.sv
// Shared audio IP definitions: stereo frame layout and I2S receiver state encoding.
// Frames carry the left sample in the upper half and the right sample in the lower half.
package psoc_audio_pkg;

    localparam int DEF_SAMPLE_BITS = 24;
    localparam int FRAME_BITS      = 2 * DEF_SAMPLE_BITS;

    localparam int LEFT_MSB  = FRAME_BITS - 1;
    localparam int LEFT_LSB  = DEF_SAMPLE_BITS;
    localparam int RIGHT_MSB = DEF_SAMPLE_BITS - 1;
    localparam int RIGHT_LSB = 0;

    typedef enum logic [1:0] {
        ST_DISABLED = 2'b00,
        ST_HUNT     = 2'b01,
        ST_LEFT     = 2'b10,
        ST_RIGHT    = 2'b11
    } rx_state_t;

endpackage

// File: rtl/i2s_in_sync.sv
// Brings the three I2S pins into the clk domain and flags sclk rising edges.
// All outputs are registered together so lrclk/sdata line up with sclk_rise.
module i2s_in_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i2s_sclk,
    input  logic i2s_lrclk,
    input  logic i2s_sdata,
    output logic sclk_rise,
    output logic lrclk_s,
    output logic sdata_s
);

    logic [SYNC_STAGES-1:0] sclk_sr;
    logic [SYNC_STAGES-1:0] lrclk_sr;
    logic [SYNC_STAGES-1:0] sdata_sr;
    logic                   sclk_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sr   <= '0;
            lrclk_sr  <= '0;
            sdata_sr  <= '0;
            sclk_d    <= 1'b0;
            sclk_rise <= 1'b0;
            lrclk_s   <= 1'b0;
            sdata_s   <= 1'b0;
        end else begin
            sclk_sr   <= {sclk_sr[SYNC_STAGES-2:0], i2s_sclk};
            lrclk_sr  <= {lrclk_sr[SYNC_STAGES-2:0], i2s_lrclk};
            sdata_sr  <= {sdata_sr[SYNC_STAGES-2:0], i2s_sdata};
            sclk_d    <= sclk_sr[SYNC_STAGES-1];
            sclk_rise <= sclk_sr[SYNC_STAGES-1] & ~sclk_d;
            lrclk_s   <= lrclk_sr[SYNC_STAGES-1];
            sdata_s   <= sdata_sr[SYNC_STAGES-1];
        end
    end

endmodule

// File: rtl/i2s_receiver.sv
// Philips I2S slave receiver: deserialises left/right slots into one stereo frame
// per lrclk period and hands it out over a valid/ready stream.
//
// Stream handshake: out_valid rises with a new frame and stays high with out_data
// stable until a cycle where out_valid & out_ready are both high; the frame is then
// consumed on that clk edge. A frame completing in the accept cycle replaces it.
module i2s_receiver
    import psoc_audio_pkg::*;
#(
    parameter int SAMPLE_BITS = DEF_SAMPLE_BITS,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     clear_flags,
    input  logic                     i2s_sclk,
    input  logic                     i2s_lrclk,
    input  logic                     i2s_sdata,
    output logic [2*SAMPLE_BITS-1:0] out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     overflow,
    output logic                     frame_err,
    output rx_state_t                fsm_state
);

    localparam int CW = $clog2(SAMPLE_BITS + 1);
    localparam logic [CW-1:0] FULL = CW'(SAMPLE_BITS);

    logic                   sclk_rise;
    logic                   lrclk_s;
    logic                   sdata_s;
    logic                   lr_prev;
    rx_state_t              state;
    logic [CW-1:0]          bit_cnt;
    logic [SAMPLE_BITS-1:0] shreg;
    logic [SAMPLE_BITS-1:0] left_hold;
    logic                   right_done;

    i2s_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .rst       (rst),
        .i2s_sclk  (i2s_sclk),
        .i2s_lrclk (i2s_lrclk),
        .i2s_sdata (i2s_sdata),
        .sclk_rise (sclk_rise),
        .lrclk_s   (lrclk_s),
        .sdata_s   (sdata_s)
    );

    logic                   lr_edge;
    logic [SAMPLE_BITS-1:0] shifted;
    logic                   word_done;

    assign lr_edge   = lrclk_s != lr_prev;
    assign shifted   = {shreg[SAMPLE_BITS-2:0], sdata_s};
    // right_done keeps a saturated right slot from re-emitting the same frame
    assign word_done = enable && (state == ST_RIGHT) && (bit_cnt == FULL) && !right_done;
    assign fsm_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data   <= '0;
            out_valid  <= 1'b0;
            overflow   <= 1'b0;
            frame_err  <= 1'b0;
            lr_prev    <= 1'b0;
            state      <= ST_DISABLED;
            bit_cnt    <= '0;
            shreg      <= '0;
            left_hold  <= '0;
            right_done <= 1'b0;
        end else begin
            if (clear_flags) begin
                overflow  <= 1'b0;
                frame_err <= 1'b0;
            end
            if (out_valid && out_ready) out_valid <= 1'b0;
            if (sclk_rise) lr_prev <= lrclk_s;

            if (word_done) begin
                right_done <= 1'b1;
                if (!out_valid || out_ready) begin
                    out_data  <= {left_hold, shreg};
                    out_valid <= 1'b1;
                end else begin
                    overflow <= 1'b1;
                end
            end

            if (!enable) begin
                state      <= ST_DISABLED;
                bit_cnt    <= '0;
                shreg      <= '0;
                left_hold  <= '0;
                right_done <= 1'b0;
            end else begin
                case (state)
                    ST_DISABLED: state <= ST_HUNT;
                    ST_HUNT: begin
                        if (sclk_rise && !lrclk_s && lr_prev) begin
                            state   <= ST_LEFT;
                            bit_cnt <= '0;
                            shreg   <= '0;
                        end
                    end
                    ST_LEFT: begin
                        if (sclk_rise) begin
                            // the rise that shows the lrclk change still carries the old slot's last bit
                            if (lr_edge) begin
                                if (bit_cnt < FULL) begin
                                    frame_err <= 1'b1;
                                    state     <= ST_HUNT;
                                end else begin
                                    state      <= ST_RIGHT;
                                    bit_cnt    <= '0;
                                    shreg      <= '0;
                                    right_done <= 1'b0;
                                end
                            end else if (bit_cnt < FULL) begin
                                shreg   <= shifted;
                                bit_cnt <= bit_cnt + CW'(1);
                                if (bit_cnt == FULL - CW'(1)) left_hold <= shifted;
                            end
                        end
                    end
                    ST_RIGHT: begin
                        if (sclk_rise) begin
                            if (lr_edge) begin
                                if (bit_cnt < FULL) frame_err <= 1'b1;
                                state   <= ST_LEFT;
                                bit_cnt <= '0;
                                shreg   <= '0;
                            end else if (bit_cnt < FULL) begin
                                shreg   <= shifted;
                                bit_cnt <= bit_cnt + CW'(1);
                            end
                        end
                    end
                    default: state <= ST_DISABLED;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2s_receiver.sv
// Directed bench for i2s_receiver: drives Philips I2S at sclk = clk/8 and checks
// frames, sticky flags, enable/reset behaviour against hand-computed values.
module tb_i2s_receiver;
    import psoc_audio_pkg::*;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        clear_flags;
    logic        i2s_sclk;
    logic        i2s_lrclk;
    logic        i2s_sdata;
    logic [47:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        overflow;
    logic        frame_err;
    rx_state_t   fsm_state;

    int          total;
    int          bad;
    logic        prev_bit;
    logic [47:0] got_q[$];

    i2s_receiver dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .clear_flags (clear_flags),
        .i2s_sclk    (i2s_sclk),
        .i2s_lrclk   (i2s_lrclk),
        .i2s_sdata   (i2s_sdata),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .overflow    (overflow),
        .frame_err   (frame_err),
        .fsm_state   (fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // inputs change 1ns after posedge, so a negedge sample sees what the next posedge uses
    always @(negedge clk) begin
        if (out_valid && out_ready) got_q.push_back(out_data);
    end

    function automatic logic [47:0] got_at(input int i);
        if (i < got_q.size()) return got_q[i];
        return 48'h0;
    endfunction

    // One slot of nbits sclk periods; sdata lags lrclk by one sclk (Philips framing).
    task automatic send_slot(input logic ch, input logic [23:0] word, input int nbits,
                             input int ev_at, input logic ev_en);
        for (int j = 0; j < nbits; j++) begin
            if (j == ev_at) enable = ev_en;
            i2s_sclk  = 1'b0;
            i2s_lrclk = ch;
            i2s_sdata = prev_bit;
            #40;
            i2s_sclk = 1'b1;
            #40;
            prev_bit = (j < 24) ? word[23-j] : 1'b0;
        end
    endtask

    task automatic send_frame(input logic [23:0] l, input logic [23:0] r, input int nbits);
        send_slot(1'b0, l, nbits, -1, 1'b0);
        send_slot(1'b1, r, nbits, -1, 1'b0);
    endtask

    task automatic pulse_clear();
        @(posedge clk); #1 clear_flags = 1'b1;
        @(posedge clk); #1 clear_flags = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
        total++; if (out_data !== 48'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", out_data); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%0b exp=0", overflow); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err got=%0b exp=0", frame_err); end
        total++; if (fsm_state !== ST_DISABLED) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", fsm_state, ST_DISABLED); end
    endtask

    task automatic test_basic();
        @(posedge clk); #1;
        got_q.delete();
        enable    = 1'b1;
        out_ready = 1'b1;
        send_slot(1'b1, 24'h0, 32, -1, 1'b0);
        send_frame(24'hABCDEF, 24'h123456, 32);
        repeat (10) @(negedge clk);
        total++; if (got_q.size() !== 1) begin bad++; $display("FAIL basic_count got=%0d exp=1", got_q.size()); end
        total++; if (got_at(0) !== 48'hABCDEF123456) begin bad++; $display("FAIL basic_data got=%h exp=abcdef123456", got_at(0)); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL basic_overflow got=%0b exp=0", overflow); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL basic_frame_err got=%0b exp=0", frame_err); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_drop got=%0b exp=0", out_valid); end
    endtask

    task automatic test_overflow();
        @(posedge clk); #1;
        got_q.delete();
        out_ready = 1'b0;
        send_frame(24'h000001, 24'hFFFFFF, 32);
        send_frame(24'h800000, 24'h7FFFFF, 32);
        send_frame(24'h5A5A5A, 24'hA5A5A5, 32);
        @(negedge clk);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL ovf_valid got=%0b exp=1", out_valid); end
        total++; if (out_data !== 48'h000001FFFFFF) begin bad++; $display("FAIL ovf_data got=%h exp=000001ffffff", out_data); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%0b exp=1", overflow); end
        pulse_clear();
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%0b exp=0", overflow); end
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        @(negedge clk);
        total++; if (got_at(0) !== 48'h000001FFFFFF || got_q.size() !== 1) begin bad++; $display("FAIL ovf_accept got=%h n=%0d exp=000001ffffff n=1", got_at(0), got_q.size()); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ovf_valid_drop got=%0b exp=0", out_valid); end
    endtask

    task automatic test_enable_mid_right();
        @(posedge clk); #1;
        got_q.delete();
        enable    = 1'b0;
        out_ready = 1'b1;
        send_slot(1'b0, 24'h111111, 32, -1, 1'b0);
        send_slot(1'b1, 24'h222222, 32, 10, 1'b1);
        send_frame(24'h333333, 24'h444444, 32);
        send_frame(24'h555555, 24'h666666, 32);
        repeat (4) @(negedge clk);
        total++; if (got_q.size() !== 2) begin bad++; $display("FAIL en_count got=%0d exp=2", got_q.size()); end
        total++; if (got_at(0) !== 48'h333333444444) begin bad++; $display("FAIL en_first got=%h exp=333333444444", got_at(0)); end
        total++; if (got_at(1) !== 48'h555555666666) begin bad++; $display("FAIL en_second got=%h exp=555555666666", got_at(1)); end
    endtask

    task automatic test_short_slots();
        @(posedge clk); #1;
        got_q.delete();
        out_ready = 1'b1;
        send_frame(24'hAAAAAA, 24'hBBBBBB, 16);
        send_frame(24'hCCCCCC, 24'hDDDDDD, 16);
        repeat (4) @(negedge clk);
        total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL short_err got=%0b exp=1", frame_err); end
        total++; if (got_q.size() !== 0) begin bad++; $display("FAIL short_no_frame got=%0d exp=0", got_q.size()); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL short_valid got=%0b exp=0", out_valid); end
        @(posedge clk); #1;
        send_frame(24'hC0FFEE, 24'hBEEF01, 32);
        send_frame(24'h13579B, 24'h2468AC, 32);
        repeat (4) @(negedge clk);
        total++; if (got_at(0) !== 48'hC0FFEEBEEF01 || got_at(1) !== 48'h13579B2468AC || got_q.size() !== 2)
            begin bad++; $display("FAIL short_recover got=%h,%h n=%0d exp=c0ffeebeef01,13579b2468ac n=2", got_at(0), got_at(1), got_q.size()); end
        total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL short_err_sticky got=%0b exp=1", frame_err); end
        pulse_clear();
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL short_err_clear got=%0b exp=0", frame_err); end
    endtask

    task automatic test_async_reset();
        @(posedge clk); #1;
        got_q.delete();
        out_ready = 1'b0;
        send_frame(24'h0F1E2D, 24'h3C4B5A, 32);
        send_frame(24'h696969, 24'h969696, 32);
        @(negedge clk);
        total++; if (out_valid !== 1'b1 || overflow !== 1'b1) begin bad++; $display("FAIL arst_pre got=%0b/%0b exp=1/1", out_valid, overflow); end
        @(posedge clk); #1;
        fork
            send_slot(1'b0, 24'h777777, 32, -1, 1'b0);
            begin
                #902 rst = 1'b1;
                #1;
                total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL arst_valid got=%0b exp=0", out_valid); end
                total++; if (out_data !== 48'h0) begin bad++; $display("FAIL arst_data got=%h exp=0", out_data); end
                total++; if (overflow !== 1'b0) begin bad++; $display("FAIL arst_overflow got=%0b exp=0", overflow); end
                total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL arst_frame_err got=%0b exp=0", frame_err); end
                total++; if (fsm_state !== ST_DISABLED) begin bad++; $display("FAIL arst_state got=%0d exp=%0d", fsm_state, ST_DISABLED); end
                #27 rst = 1'b0;
            end
        join
        out_ready = 1'b1;
        send_slot(1'b1, 24'h888888, 32, -1, 1'b0);
        send_frame(24'hABABAB, 24'hCDCDCD, 32);
        repeat (4) @(negedge clk);
        total++; if (got_q.size() !== 1) begin bad++; $display("FAIL arst_count got=%0d exp=1", got_q.size()); end
        total++; if (got_at(0) !== 48'hABABABCDCDCD) begin bad++; $display("FAIL arst_resume got=%h exp=ababab cdcdcd", got_at(0)); end
    endtask

    task automatic test_disable_hold();
        @(posedge clk); #1;
        got_q.delete();
        out_ready = 1'b0;
        send_frame(24'h0F0F0F, 24'hF0F0F0, 32);
        send_slot(1'b0, 24'h121212, 32, -1, 1'b0);
        send_slot(1'b1, 24'h343434, 32, 10, 1'b0);
        @(negedge clk);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL dis_valid got=%0b exp=1", out_valid); end
        total++; if (out_data !== 48'h0F0F0FF0F0F0) begin bad++; $display("FAIL dis_data got=%h exp=0f0f0ff0f0f0", out_data); end
        total++; if (fsm_state !== ST_DISABLED) begin bad++; $display("FAIL dis_state got=%0d exp=%0d", fsm_state, ST_DISABLED); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL dis_overflow got=%0b exp=0", overflow); end
        @(posedge clk); #1;
        enable    = 1'b1;
        out_ready = 1'b1;
        send_frame(24'h565656, 24'h787878, 32);
        repeat (4) @(negedge clk);
        total++; if (got_q.size() !== 2) begin bad++; $display("FAIL dis_count got=%0d exp=2", got_q.size()); end
        total++; if (got_at(0) !== 48'h0F0F0FF0F0F0) begin bad++; $display("FAIL dis_held got=%h exp=0f0f0ff0f0f0", got_at(0)); end
        total++; if (got_at(1) !== 48'h565656787878) begin bad++; $display("FAIL dis_next got=%h exp=565656787878", got_at(1)); end
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        rst         = 1'b1;
        enable      = 1'b0;
        clear_flags = 1'b0;
        i2s_sclk    = 1'b1;
        i2s_lrclk   = 1'b0;
        i2s_sdata   = 1'b0;
        out_ready   = 1'b0;
        prev_bit    = 1'b0;
        test_reset();
        test_basic();
        test_overflow();
        test_enable_mid_right();
        test_short_slots();
        test_async_reset();
        test_disable_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
